// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage.
// Computes MULTU/MULT/DIVU/DIV one shift-add / shift-subtract step per cycle
// and returns a registered {hi,lo} result with a ready handshake.
//
// Handshake: EX holds start_i high until it samples ready_o=1. The unit keeps
// ready_o and result_o stable in DONE until start_i drops or annul_i rises.
// stallreq_o is high while a request is pending and its result is not ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start_i, op_i       request and operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   opdata1_i/2_i       multiplicand/dividend, multiplier/divisor
//   annul_i             cancel current or requested operation
//   result_o            {hi,lo}: product, or {remainder, quotient}
//   ready_o, div_zero_o registered result-valid and divide-by-zero flags
//   stallreq_o          combinational stall request toward the pipeline
//   dbg_state           current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 div_zero_o,
  output logic                 stallreq_o,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   opa_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH:0]   acc_q;     // mul: {carry, hi, lo}; div: {rem(W+1), quot(W)}
  logic [CNT_W-1:0]   cnt_q;

  logic               s1, s2, start_ok, zero_div;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, mul_hi;
  logic [2*WIDTH:0]   mul_next, div_next, step_next;
  logic [WIDTH:0]     rem_sh, rem_diff, rem_new;
  logic               borrow;
  logic [2*WIDTH-1:0] prod, prod_fin, res_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin;

  assign stallreq_o = start_i & ~ready_o & ~annul_i;
  assign dbg_state  = state_q;

  // Operand magnitudes: signed ops take the two's-complement absolute value.
  assign s1       = op_i[0] & opdata1_i[WIDTH-1];
  assign s2       = op_i[0] & opdata2_i[WIDTH-1];
  assign mag1     = s1 ? -opdata1_i : opdata1_i;
  assign mag2     = s2 ? -opdata2_i : opdata2_i;
  assign start_ok = start_i & ~annul_i;
  assign zero_div = op_i[1] & (opdata2_i == '0);

  // Multiply step: conditional add into the upper half, then shift right.
  assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, opa_q};
  assign mul_hi   = acc_q[0] ? mul_sum : acc_q[2*WIDTH:WIDTH];
  assign mul_next = {1'b0, mul_hi, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift {rem,quot} left, trial-subtract the divisor.
  // When the shifted remainder reaches 2^WIDTH it always exceeds the divisor,
  // so the restored value in the borrow case keeps a zero top bit.
  assign rem_sh             = acc_q[2*WIDTH-1:WIDTH-1];
  assign {borrow, rem_diff} = {1'b0, rem_sh} - {2'b00, opa_q};
  assign rem_new            = borrow ? rem_sh : rem_diff;
  assign div_next           = {rem_new, acc_q[WIDTH-2:0], ~borrow};

  assign step_next = is_div_q ? div_next : mul_next;

  // Sign correction applied to the final step's value.
  assign prod     = step_next[2*WIDTH-1:0];
  assign prod_fin = neg_res_q ? -prod : prod;
  assign quot_fin = neg_res_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
  assign rem_fin  = neg_rem_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  assign res_fin  = is_div_q ? {rem_fin, quot_fin} : prod_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = zero_div ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (annul_i)               state_d = S_IDLE;
        else if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: if (!start_i || annul_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      opa_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      // ready_o rises one edge after entering DONE and stays while the
      // request is still held.
      ready_o <= (state_q == S_DONE) & start_i & ~annul_i;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            is_div_q   <= op_i[1];
            neg_res_q  <= s1 ^ s2;
            neg_rem_q  <= s1;
            cnt_q      <= '0;
            opa_q      <= op_i[1] ? mag2 : mag1;
            acc_q      <= {{(WIDTH+1){1'b0}}, (op_i[1] ? mag1 : mag2)};
            div_zero_o <= zero_div;
            if (zero_div) result_o <= '0;
          end
        end
        S_BUSY: begin
          if (!annul_i) begin
            acc_q <= step_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) result_o <= res_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
